soa_bin_sequencer: RTL
======================

# soa_bin_sequencer

Per-sample bin scheduler that drives the sum-of-oscillators accumulator stage. On every audio sample tick it sweeps all frequency bins. For each bin it:
- advances a per-bin phase accumulator held in internal RAM,
- fetches the bin's frequency increment and gain from an external table,
- emits one accumulate strobe.

It then closes the sample with a single save strobe carrying the compression word. It sits directly upstream of the accumulator stage and feeds its `phase_i`, `freq_gain_i`, `accumulate_i`, `save_i` and `compression_i` inputs.

## Interface
Parameters:
- `DW`, 18, gain width (matches accumulator stage)
- `AW`, 11, phase output is `AW+1` bits (full circle, top 2 bits = quadrant)
- `NBINS`, 256, number of bins, power of two, ≥4
- `BW`, `$clog2(NBINS)`, bin index width
- `PHW`, 24, phase accumulator width, ≥ `AW+1`

Ports:
- `clk_i` in 1: clock
- `arst_n_i` in 1: reset, asynchronous, active-low
- `sample_tick_i` in 1: one-cycle sample-rate strobe
- `phase_clear_i` in 1: request re-zeroing of all phase accumulators
- `compression_i` in 12: compression word, sampled at tick acceptance
- `bin_addr_o` out BW: table read address
- `inc_i` in PHW: frequency increment for `bin_addr_o`, valid 1 cycle after address
- `gain_i` in DW: gain for `bin_addr_o`, valid 1 cycle after address
- `phase_o` out AW+1: bin phase
- `freq_gain_o` out DW: bin gain
- `accumulate_o` out 1: bin valid strobe
- `save_o` out 1: end-of-sample strobe
- `compression_o` out 12: compression word for current sample
- `busy_o` out 1: sweep, init or drain in progress
- `overrun_o` out 1: sticky, tick arrived while busy

## Operation
- Phase RAM: `NBINS`×`PHW`, synchronous read, one write port. Not reset-initialised; cleared by the INIT sweep.
- FSM states: INIT, IDLE, RUN, DRAIN, SAVE.
  - INIT: entered on reset release and on `phase_clear_i` seen in IDLE. Writes 0 to entries 0..NBINS-1, one per cycle, then goes to IDLE. Ticks arriving in INIT are dropped without setting `overrun_o`.
  - IDLE: on `sample_tick_i`, latches `compression_i` into `compression_o`, clears the bin counter and goes to RUN. If tick and `phase_clear_i` arrive in the same cycle, the tick wins and the clear is ignored.
  - RUN: `bin_addr_o` = counter, and the phase RAM reads the same address. Counter increments each cycle; after `NBINS-1` the FSM goes to DRAIN.
  - DRAIN: 2 cycles while the pipeline empties, then SAVE.
  - SAVE: 1 cycle, then IDLE.
- Per-bin pipeline:
  - stage 1: address issued.
  - stage 2: `inc_i`, `gain_i` and the phase RAM word are valid. `new = old + inc` mod 2^PHW is written back to the same address. Outputs are registered with `phase_o = old[PHW-1 -: AW+1]` (pre-increment phase) and `freq_gain_o = gain_i`.
- Write-back to bin k and read of bin k+1 occur in the same cycle at different addresses, so there is no collision.
- `accumulate_o` and `save_o` are never high in the same cycle. Save is issued only after the last accumulate, because the downstream stage gives save priority and would lose a coincident bin.
- `freq_gain_o` is 0 whenever `accumulate_o` is 0. `phase_o` holds its last value.
- `compression_o` is stable from acceptance through SAVE. `compression_i` changes mid-sweep are ignored.
- Overrun:
  - A tick in RUN, DRAIN or SAVE is dropped and sets `overrun_o`.
  - `overrun_o` clears only on reset.
  - The current sweep is unaffected.

## Timing
- Tick sampled in cycle T (IDLE):
  - `busy_o` = 1 in T+1..T+NBINS+3.
  - Bin k address in T+1+k.
  - Bin k `accumulate_o` in T+3+k.
  - `save_o` in T+NBINS+3.
  - Earliest next accepted tick is T+NBINS+4. Minimum tick period is NBINS+4 cycles.
- INIT lasts NBINS cycles with `busy_o` = 1. It starts the first clock after reset deassertion.
- Reset (async, any time):
  - `phase_o`, `freq_gain_o`, `accumulate_o`, `save_o`, `compression_o`, `bin_addr_o`, `overrun_o` = 0 immediately.
  - `busy_o` = 1 and state = INIT while asserted.
  - A sweep in progress is abandoned and no save is emitted.
- Phase wrap is modulo 2^PHW with no saturation or flag.

## Test plan
Bench configuration: NBINS=8, PHW=24, AW=11.
- Reset release: `busy_o` high exactly 8 cycles. A tick at cycle 3 of INIT is dropped and `overrun_o` stays 0. A following tick is accepted.
- First tick with `inc`=0x100000 for all bins, `gain_i`=bin index, `compression_i`=0x800:
  - `accumulate_o` high T+3..T+10, `freq_gain_o` 0..7, `phase_o` all 0.
  - `save_o` high at T+11 with `accumulate_o`=0 and `compression_o`=0x800.
- Second tick: every bin reports `phase_o`=0x100. Third tick: every bin reports 0x200.
- Wrap: bin 3 `inc`=0x800000 gives `phase_o` 0x000, 0x800, 0x000 on ticks 1..3.
- Overrun: tick at T+5 during RUN gives `overrun_o`=1 from T+6 and remains 1. The save still occurs at T+11 and the next tick at T+12 is accepted.
- Async reset at T+6:
  - All outputs 0 that cycle, no `save_o`.
  - After release, an 8-cycle INIT runs, then a tick yields `phase_o`=0 for all bins.

Source files
------------

// File: rtl/soa_bin_sequencer.sv
// Per-sample bin scheduler for the sum-of-oscillators accumulator: sweeps all bins on
// each sample tick, advancing per-bin phase in internal RAM, then closes with one save strobe.
module soa_bin_sequencer #(
  parameter int DW    = 18,
  parameter int AW    = 11,
  parameter int NBINS = 256,
  parameter int BW    = $clog2(NBINS),
  parameter int PHW   = 24
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          sample_tick_i,
  input  logic          phase_clear_i,
  input  logic [11:0]   compression_i,
  output logic [BW-1:0] bin_addr_o,
  input  logic [PHW-1:0] inc_i,
  input  logic [DW-1:0] gain_i,
  output logic [AW:0]   phase_o,
  output logic [DW-1:0] freq_gain_o,
  output logic          accumulate_o,
  output logic          save_o,
  output logic [11:0]   compression_o,
  output logic          busy_o,
  output logic          overrun_o
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_DRAIN, S_SAVE} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  cnt, cnt_nxt;
  logic           accept, drop;

  logic           s2_valid;
  logic [BW-1:0]  s2_addr;
  logic [PHW-1:0] rd_data;
  logic [PHW-1:0] phase_sum;

  logic           ram_we;
  logic [BW-1:0]  ram_waddr;
  logic [PHW-1:0] ram_wdata;
  logic [PHW-1:0] phase_ram [NBINS];

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together on the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      S_INIT: begin
        cnt_nxt = cnt + BW'(1);
        if (cnt == BW'(NBINS - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (sample_tick_i) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end else if (phase_clear_i) begin
          cnt_nxt   = '0;
          state_nxt = S_INIT;
        end
      end
      S_RUN: begin
        drop    = sample_tick_i;
        cnt_nxt = cnt + BW'(1);
        if (cnt == BW'(NBINS - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        drop = sample_tick_i;
        if (cnt == BW'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_SAVE;
        end else begin
          cnt_nxt = cnt + BW'(1);
        end
      end
      S_SAVE: begin
        drop      = sample_tick_i;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign bin_addr_o = cnt;
  assign save_o     = (state == S_SAVE);
  assign busy_o     = (state != S_IDLE);

  // Write-back of bin k lands in the same cycle as the read of bin k+1, so the
  // single write port never collides with the read address during a sweep.
  assign phase_sum = rd_data + inc_i;
  assign ram_we    = (state == S_INIT) || s2_valid;
  assign ram_waddr = s2_valid ? s2_addr : cnt;
  assign ram_wdata = s2_valid ? phase_sum : '0;

  // NOTE: the phase RAM has no reset; the INIT sweep zeroes it, which keeps it
  // mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (ram_we) phase_ram[ram_waddr] <= ram_wdata;
    rd_data <= phase_ram[cnt];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s2_valid      <= 1'b0;
      s2_addr       <= '0;
      accumulate_o  <= 1'b0;
      freq_gain_o   <= '0;
      phase_o       <= '0;
      compression_o <= '0;
      overrun_o     <= 1'b0;
    end else begin
      s2_valid     <= (state == S_RUN);
      s2_addr      <= cnt;
      accumulate_o <= s2_valid;
      freq_gain_o  <= s2_valid ? gain_i : '0;
      if (s2_valid) phase_o <= rd_data[PHW-1 -: AW+1];
      if (accept)   compression_o <= compression_i;
      if (drop)     overrun_o <= 1'b1;
    end
  end

endmodule
